// File: rtl/kb_cmd_sequencer.sv
// Keyboard command sequencer: pops make codes from the receive FIFO, runs the stopwatch
// run/direction state and the BCD preset-entry mode. KB_ENTRY_TIMEOUT_EN adds an idle auto-abort in ENTRY.
module kb_cmd_sequencer #(
    parameter int unsigned TIMEOUT_CYC = 250_000_000,
    parameter int unsigned TW          = 28
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_empty,
    input  logic [8:0]  rd_data,
    output logic        rd_fifo,
    output logic        up,
    output logic        go,
    output logic        clr,
    output logic        load,
    output logic [23:0] load_val,
    output logic        entry_mode,
    output logic [23:0] entry_buf,
    output logic [2:0]  entry_cnt
);

    typedef enum logic {IDLE, ENTRY} state_t;

    state_t      state, state_nxt;
    logic        rd_fifo_nxt, up_nxt, go_nxt, clr_nxt, load_nxt;
    logic [23:0] load_val_nxt, entry_buf_nxt;
    logic [2:0]  entry_cnt_nxt;

    logic        pop;
    logic [7:0]  code;
    logic        shifted;
    logic        is_digit;
    logic [3:0]  digit;
    logic        timeout;

    if (64'(TIMEOUT_CYC) >= (64'd1 << TW)) begin : g_tw_check
        $error("TW too narrow for TIMEOUT_CYC");
    end

    // Sampling only while rd_fifo is low paces consumption to one code per two cycles.
    assign pop     = !fifo_empty && !rd_fifo;
    assign code    = rd_data[7:0];
    assign shifted = rd_data[8];

    always_comb begin
        is_digit = 1'b1;
        digit    = 4'd0;
        case (code)
            8'h45: digit = 4'd0;
            8'h16: digit = 4'd1;
            8'h1E: digit = 4'd2;
            8'h26: digit = 4'd3;
            8'h25: digit = 4'd4;
            8'h2E: digit = 4'd5;
            8'h36: digit = 4'd6;
            8'h3D: digit = 4'd7;
            8'h3E: digit = 4'd8;
            8'h46: digit = 4'd9;
            default: is_digit = 1'b0;
        endcase
    end

`ifdef KB_ENTRY_TIMEOUT_EN
    logic [TW-1:0] to_cnt;

    assign timeout = (state == ENTRY) && !rd_fifo && (to_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || state != ENTRY || rd_fifo || timeout)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        rd_fifo_nxt   = pop;
        up_nxt        = up;
        go_nxt        = go;
        clr_nxt       = 1'b0;
        load_nxt      = 1'b0;
        load_val_nxt  = load_val;
        entry_buf_nxt = entry_buf;
        entry_cnt_nxt = entry_cnt;

        // Decoding on the sampling edge makes effects visible alongside the rd_fifo pulse.
        if (pop) begin
            unique case (state)
                IDLE: begin
                    case (code)
                        8'h21: begin clr_nxt = 1'b1; up_nxt = 1'b1; end
                        8'h34: go_nxt = 1'b1;
                        8'h4D: go_nxt = 1'b0;
                        8'h3C: up_nxt = !up;
                        8'h4B: begin
                            go_nxt        = 1'b0;
                            entry_buf_nxt = '0;
                            entry_cnt_nxt = '0;
                            state_nxt     = ENTRY;
                        end
                        default: ;
                    endcase
                end
                ENTRY: begin
                    if (is_digit) begin
                        if (!shifted && entry_cnt < 3'd6) begin
                            entry_buf_nxt = {entry_buf[19:0], digit};
                            entry_cnt_nxt = entry_cnt + 3'd1;
                        end
                    end else begin
                        case (code)
                            8'h66: if (entry_cnt != 3'd0) begin
                                entry_buf_nxt = {4'h0, entry_buf[23:4]};
                                entry_cnt_nxt = entry_cnt - 3'd1;
                            end
                            8'h5A: begin
                                load_val_nxt = entry_buf;
                                load_nxt     = 1'b1;
                                state_nxt    = IDLE;
                            end
                            8'h76: state_nxt = IDLE;
                            default: ;
                        endcase
                    end
                end
            endcase
        end else if (timeout) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rd_fifo    <= 1'b0;
            up         <= 1'b1;
            go         <= 1'b0;
            clr        <= 1'b0;
            load       <= 1'b0;
            load_val   <= '0;
            entry_mode <= 1'b0;
            entry_buf  <= '0;
            entry_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            rd_fifo    <= rd_fifo_nxt;
            up         <= up_nxt;
            go         <= go_nxt;
            clr        <= clr_nxt;
            load       <= load_nxt;
            load_val   <= load_val_nxt;
            entry_mode <= (state_nxt == ENTRY);
            entry_buf  <= entry_buf_nxt;
            entry_cnt  <= entry_cnt_nxt;
        end
    end

endmodule

// File: doc/kb_cmd_sequencer.md
Name: kb_cmd_sequencer

Overview:
Command sequencer between the PS/2 keyboard receiver's make-code FIFO and the stopwatch core. It pops one code at a time from the FIFO and decodes the single-key commands (clear, go, pause, reverse). It also runs a multi-key preset-entry mode: the user types up to 6 BCD digits, and the value is loaded into the stopwatch. It owns the up/go run state and the clr/load strobes that drive the counter.

Parameters:
TIMEOUT_CYC, 250_000_000, idle cycles in ENTRY before auto-abort (optional feature only)
TW, 28, width of the timeout counter; must satisfy 2^TW > TIMEOUT_CYC

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
fifo_empty  in  1  code FIFO empty flag
rd_data  in  9  {shift, make_code[7:0]}; first-word-fall-through, valid whenever fifo_empty=0
rd_fifo  out  1  FIFO pop strobe, one cycle per consumed code
up  out  1  count direction: 1=up, 0=down
go  out  1  1=run, 0=pause
clr  out  1  one-cycle clear strobe to stopwatch
load  out  1  one-cycle preset-load strobe
load_val  out  24  six BCD digits, [3:0]=digit0 (rightmost)
entry_mode  out  1  1 while in ENTRY (display shows entry_buf)
entry_buf  out  24  digits typed so far, BCD
entry_cnt  out  3  number of digits typed, 0..6

Behaviour:
- Reset (sync, rst=1 at posedge clk): state=IDLE, up=1, go=0, clr=0, load=0, rd_fifo=0, load_val=0, entry_mode=0, entry_buf=0, entry_cnt=0, timeout counter=0.
- Two states: IDLE and ENTRY. All outputs are registered.
- Pop rule: when fifo_empty=0 and rd_fifo=0 in a cycle, the block samples rd_data and asserts rd_fifo for the next cycle. At most one code is consumed every 2 cycles. rd_fifo is never asserted while fifo_empty=1.
- Decode effects appear in the same cycle that rd_fifo is high. Strobes (clr, load) are 1 cycle wide.
- IDLE decode, using rd_data[7:0]:
  - 0x21 (C): clr=1, up=1.
  - 0x34 (G): go=1.
  - 0x4D (P): go=0.
  - 0x3C (U): up toggles.
  - 0x4B (L): go=0, entry_buf=0, entry_cnt=0, enter ENTRY, entry_mode=1.
  - Digits and any other code: consumed, no effect.
- ENTRY decode; the digit codes are 0x45,16,1E,26,25,2E,36,3D,3E,46 for values 0..9:
  - Digit with shift=0 and entry_cnt<6: entry_buf <= {entry_buf[19:0], digit}, entry_cnt+1.
  - Digit when entry_cnt=6, or digit with shift=1: consumed and ignored.
  - 0x66 (Backspace): if entry_cnt>0, entry_buf <= {4'h0, entry_buf[23:4]}, entry_cnt-1; if entry_cnt=0, no effect.
  - 0x5A (Enter): load_val <= entry_buf, load=1, return to IDLE, entry_mode=0. go stays 0 and up is unchanged.
  - 0x76 (Esc): return to IDLE with no load. entry_buf and load_val are unchanged.
  - C/G/P/U/L and other codes: consumed, no effect; go stays 0 throughout ENTRY.
- Enter with entry_cnt=0: loads 0x000000 (valid preset).
- clr and load are never asserted in the same cycle.
- Reset mid-entry discards the buffer and forces IDLE. A code already popped is lost; the FIFO is not rewound.

Optional Feature:
KB_ENTRY_TIMEOUT_EN
- Defined: in ENTRY, a counter counts cycles since entering ENTRY or since the last consumed code.
  - It clears on every pop.
  - When it reaches TIMEOUT_CYC-1 with no pop that cycle, the block behaves as Esc on the next cycle: returns to IDLE, no load.
  - The counter is held at 0 in IDLE.
- Not defined: no counter is instantiated and ENTRY persists indefinitely. TIMEOUT_CYC and TW are unused.

Test Plan:
1. Reset, then FIFO supplies 0x34 -> rd_fifo 1 cycle, go=1; then 0x4D -> go=0; then 0x3C twice -> up goes 1->0->1.
2. go=1, up=0, then 0x21 -> clr high exactly 1 cycle, up=1, go stays 1.
3. 0x4B, 0x16, 0x1E, 0x26, 0x5A -> go=0 at L; entry_buf=0x000123, entry_cnt=3; load 1 cycle with load_val=0x000123; entry_mode=0.
4. 0x4B, then digits 1..7 (7 codes), 0x66, 0x5A -> after 6 digits entry_buf=0x123456 and the 7th is ignored; backspace gives entry_buf=0x012345, entry_cnt=5; load_val=0x012345.
5. 0x4B, 0x25, 0x76 -> IDLE, no load pulse, load_val keeps its prior value. 0x4B, then rst=1 for 1 cycle -> all reset values.
6. With KB_ENTRY_TIMEOUT_EN and TIMEOUT_CYC=16: 0x4B, then FIFO held empty -> entry_mode drops 17 cycles after the L pop, no load. A digit at cycle 10 restarts the count. Without the macro, entry_mode stays 1 for 1000 cycles.
